regfile_wb_arbiter: RTL



---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_slot.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the index-to-onehot decoder used by
// the writeback arbiter and the regfile write-enable decode.
package regfile_pkg;

    localparam int WIDTH   = 32;
    localparam int KEY_LEN = 5;
    localparam int REGNUM  = 32;

    function automatic logic [REGNUM-1:0] onehot(input logic [KEY_LEN-1:0] idx);
        logic [REGNUM-1:0] vec;
        vec      = {REGNUM{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register: flush discards, load wins over drain
// so a slot drained and refilled in the same cycle stays valid.
module wb_slot
    import regfile_pkg::*;
#(
    parameter int SLOT_WIDTH   = WIDTH,
    parameter int SLOT_KEY_LEN = KEY_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    load_i,
    input  logic                    drain_i,
    input  logic [SLOT_KEY_LEN-1:0] addr_i,
    input  logic [SLOT_WIDTH-1:0]   data_i,
    output logic                    valid_o,
    output logic [SLOT_KEY_LEN-1:0] addr_o,
    output logic [SLOT_WIDTH-1:0]   data_o
);

    logic                    valid_q, valid_d;
    logic [SLOT_KEY_LEN-1:0] addr_q, addr_d;
    logic [SLOT_WIDTH-1:0]   data_q, data_d;

    // Next-state selection for the slot contents.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= {SLOT_KEY_LEN{1'b0}};
            data_q  <= {SLOT_WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the EXU (slot 0)
// and LSU (slot 1) writeback slots; also exports the pending-write mask.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [KEY_LEN-1:0] req0_addr,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [KEY_LEN-1:0] req1_addr,
    input  logic [WIDTH-1:0]   req1_data,
    output logic [KEY_LEN-1:0] writereg,
    output logic [WIDTH-1:0]   data,
    output logic               writeEn,
    output logic [REGNUM-1:0]  pending,
    output logic [1:0]         grant
);

    logic               v0_s, v1_s;
    logic [KEY_LEN-1:0] a0_s, a1_s;
    logic [WIDTH-1:0]   d0_s, d1_s;
    logic [1:0]         grant_s;
    logic               last_q, last_d;
    logic [KEY_LEN-1:0] wreg_s;
    logic [WIDTH-1:0]   wdata_s;
    logic [REGNUM-1:0]  pending_s;
    logic               load0_s, load1_s;

    // Ready depends only on slot state, grant and flush, never on valid.
    assign req0_ready = !rst && !flush && (!v0_s || grant_s[0]);
    assign req1_ready = !rst && !flush && (!v1_s || grant_s[1]);
    assign load0_s    = req0_valid && req0_ready;
    assign load1_s    = req1_valid && req1_ready;

    wb_slot u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (load0_s),
        .drain_i (grant_s[0]),
        .addr_i  (req0_addr),
        .data_i  (req0_data),
        .valid_o (v0_s),
        .addr_o  (a0_s),
        .data_o  (d0_s)
    );

    wb_slot u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (load1_s),
        .drain_i (grant_s[1]),
        .addr_i  (req1_addr),
        .data_i  (req1_data),
        .valid_o (v1_s),
        .addr_o  (a1_s),
        .data_o  (d1_s)
    );

    // Round-robin grant: under contention the slot not granted last wins.
    always_comb begin
        case ({v1_s, v0_s})
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Round-robin pointer next state.
    always_comb begin
        if (grant_s != 2'b00) begin
            last_d = grant_s[1];
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin pointer; resets to 1 so slot 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // Write-port mux from the granted slot.
    always_comb begin
        wreg_s  = {KEY_LEN{1'b0}};
        wdata_s = {WIDTH{1'b0}};
        case (grant_s)
            2'b01: begin
                wreg_s  = a0_s;
                wdata_s = d0_s;
            end
            2'b10: begin
                wreg_s  = a1_s;
                wdata_s = d1_s;
            end
            default: begin
                wreg_s  = {KEY_LEN{1'b0}};
                wdata_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Pending mask over valid slots; x0 is never reported as pending.
    always_comb begin
        pending_s = {REGNUM{1'b0}};
        if (v0_s) begin
            pending_s = pending_s | onehot(a0_s);
        end else begin
            pending_s = pending_s;
        end
        if (v1_s) begin
            pending_s = pending_s | onehot(a1_s);
        end else begin
            pending_s = pending_s;
        end
        pending_s[0] = 1'b0;
    end

    assign grant    = grant_s;
    assign writereg = wreg_s;
    assign data     = wdata_s;
    assign writeEn  = (grant_s != 2'b00) && (wreg_s != {KEY_LEN{1'b0}});
    assign pending  = pending_s;

endmodule
